aes_ctr_controller: RTL

Sequencer that runs the existing aes_128_encrypt core in CTR mode. It latches key and initial counter block, accepts plaintext blocks over a valid/ready stream, and pulses the core with the current counter block. It XORs the returned keystream with the held input block, presents the result on an output valid/ready stream, then increments the counter. It sits between the AXI4-Lite register file and the AES core; the core is instantiated beside it, not inside it.

---
 rtl/aes_ctr_pkg.sv | 21 ++
 rtl/ctr_increment.sv | 32 +++
 rtl/aes_ctr_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/aes_ctr_pkg.sv
// ---------------------------------------------------------------------------
// aes_ctr_pkg
//   Types and widths shared by the AES-128 CTR-mode sequencer and its
//   counter-increment helper.
//   Contents:
//     BLOCK_W / KEY_W : AES block and key widths (128 bits each)
//     ctr_state_e     : sequencer states S_IDLE, S_START, S_WAIT, S_OUT
// ---------------------------------------------------------------------------
package aes_ctr_pkg;

    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } ctr_state_e;

endpackage : aes_ctr_pkg

// File: rtl/ctr_increment.sv
// ---------------------------------------------------------------------------
// ctr_increment
//   Combinational masked increment of a 128-bit counter block. Only the low
//   CTR_WIDTH bits count (modulo 2^CTR_WIDTH). The bits above them pass
//   through untouched, so a carry out of the counter field is dropped.
//   Ports:
//     blk_i : current counter block
//     blk_o : counter block with the low CTR_WIDTH bits incremented
// ---------------------------------------------------------------------------
module ctr_increment
    import aes_ctr_pkg::*;
#(
    parameter int CTR_WIDTH = 32
) (
    input  logic [BLOCK_W-1:0] blk_i,
    output logic [BLOCK_W-1:0] blk_o
);

    generate
        if (CTR_WIDTH >= BLOCK_W) begin : g_full
            // The whole block is the counter field.
            assign blk_o = blk_i + BLOCK_W'(1);
        end else begin : g_part
            logic [CTR_WIDTH-1:0] low_inc;

            // Self-determined width: the carry out of the counter field is lost.
            assign low_inc = blk_i[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
            assign blk_o   = {blk_i[BLOCK_W-1:CTR_WIDTH], low_inc};
        end
    endgenerate

endmodule : ctr_increment

// File: rtl/aes_ctr_controller.sv
// ---------------------------------------------------------------------------
// aes_ctr_controller
//   Runs an external aes_128_encrypt core in CTR mode. Key and initial counter
//   block are captured on cfg_load. Each accepted input block is held while
//   the core encrypts the current counter block. The keystream that comes back
//   is XORed with the held block and offered downstream. The counter advances
//   only after the result block has been handed off.
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     cfg_load/cfg_key/cfg_iv    : one-cycle key / initial counter capture
//     in_valid/in_ready/in_data  : input block stream
//     out_valid/out_ready/out_data : result block stream
//     core_start/core_plaintext/core_key : request to the AES core
//     core_ciphertext/core_done  : keystream response from the AES core
//     busy        : sequencer is not idle
//     cfg_ready   : key/IV loaded since reset
//     err_timeout : sticky core-timeout flag, cleared by cfg_load
//     block_count : blocks completed since the last cfg_load
// ---------------------------------------------------------------------------
module aes_ctr_controller
    import aes_ctr_pkg::*;
#(
    parameter int CTR_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [KEY_W-1:0]   cfg_key,
    input  logic [BLOCK_W-1:0] cfg_iv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_plaintext,
    output logic [KEY_W-1:0]   core_key,
    input  logic [BLOCK_W-1:0] core_ciphertext,
    input  logic               core_done,
    output logic               busy,
    output logic               cfg_ready,
    output logic               err_timeout,
    output logic [31:0]        block_count
);

    // The timeout counter must be able to hold TIMEOUT_CYCLES-1.
    localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    ctr_state_e          state_q,     state_d;
    logic [KEY_W-1:0]    key_q,       key_d;
    logic [BLOCK_W-1:0]  ctr_q,       ctr_d;
    logic [BLOCK_W-1:0]  data_q,      data_d;
    logic [BLOCK_W-1:0]  out_data_q,  out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                err_q,       err_d;
    logic [31:0]         count_q,     count_d;
    logic [TMO_W-1:0]    tmo_q,       tmo_d;

    logic [BLOCK_W-1:0]  ctr_inc;
    logic                in_ready_w;

    ctr_increment #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_ctr_increment (
        .blk_i (ctr_q),
        .blk_o (ctr_inc)
    );

    // cfg_load takes priority over a block arriving in the same idle cycle.
    assign in_ready_w = (state_q == S_IDLE) && cfg_ready_q && !cfg_load;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        ctr_d       = ctr_q;
        data_d      = data_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cfg_ready_d = cfg_ready_q;
        err_d       = err_q;
        count_d     = count_q;
        tmo_d       = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_load) begin
                    key_d       = cfg_key;
                    ctr_d       = cfg_iv;
                    cfg_ready_d = 1'b1;
                    err_d       = 1'b0;
                    count_d     = 32'd0;
                end else if (in_valid && in_ready_w) begin
                    data_d  = in_data;
                    state_d = S_START;
                end
            end

            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A done in the last allowed cycle still counts as success.
                if (core_done) begin
                    out_data_d  = data_q ^ core_ciphertext;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else if (tmo_q == TMO_LAST) begin
                    // Drop the block; the counter stays where it was.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ctr_d       = ctr_inc;
                    count_d     = count_q + 32'd1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            ctr_q       <= '0;
            data_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cfg_ready_q <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= 32'd0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            ctr_q       <= ctr_d;
            data_q      <= data_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cfg_ready_q <= cfg_ready_d;
            err_q       <= err_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
        end
    end

    assign in_ready       = in_ready_w;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign core_start     = (state_q == S_START);
    assign core_plaintext = ctr_q;
    assign core_key       = key_q;
    assign busy           = (state_q != S_IDLE);
    assign cfg_ready      = cfg_ready_q;
    assign err_timeout    = err_q;
    assign block_count    = count_q;

endmodule : aes_ctr_controller
